// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: tracks pending destination-register tags through the
// EX/MEM/WB stages. It also produces the PC, IF/ID and ID/EX control for
// hazard stalls and whole-pipeline holds. A watchdog raises a sticky error
// flag if a stall lasts longer than the pipeline can legitimately need.
// Optional feature: define STALL_STATS_EN to add a saturating 16-bit
// bubble counter on the stall_count port.
module pipe_dest_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode_decode,
  input  logic [2:0]  w_decode,
  input  logic        stall,
  input  logic        hold,
  output logic [2:0]  w_exec,
  output logic [2:0]  w_mem,
  output logic [2:0]  w_wb,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        stall_err
`ifdef STALL_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] run_len;
  logic       writes;
  logic [2:0] issued_tag;

  // Opcodes 1..10 write a register. Tag 0 already means "no write", so a
  // zero destination needs no special case.
  always_comb begin
    writes     = (opcode_decode >= 4'd1) && (opcode_decode <= 4'd10);
    issued_tag = writes ? w_decode : 3'd0;
  end

  // Pipeline enables follow the inputs directly. Hold freezes everything,
  // including the bubble, so it takes priority over stall.
  always_comb begin
    pc_en       = ~hold & ~stall;
    ifid_en     = ~hold & ~stall;
    idex_bubble = ~hold & stall;
  end

  // Destination tag shift register. A stalled decode slot enters EX as a
  // bubble (tag 0), and hold freezes all three stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_exec <= 3'd0;
      w_mem  <= 3'd0;
      w_wb   <= 3'd0;
    end else if (!hold) begin
      w_wb   <= w_mem;
      w_mem  <= w_exec;
      w_exec <= stall ? 3'd0 : issued_tag;
    end
  end

  // Stall watchdog FSM. The entry cycle into STALLED counts as the first
  // stall cycle and leaves run_len at 0. Each later stall cycle advances
  // run_len, so run_len >= 2 on a stall cycle marks the 4th consecutive
  // bubble. That is one more than any real hazard needs, so it is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      run_len   <= 2'd0;
      stall_err <= 1'b0;
    end else if (!hold) begin
      case (state)
        RUN: begin
          run_len <= 2'd0;
          if (stall) begin
            state <= STALLED;
          end
        end
        STALLED: begin
          if (stall) begin
            if (run_len >= 2'd2) begin
              stall_err <= 1'b1;
            end
            if (run_len != 2'd3) begin
              run_len <= run_len + 2'd1;
            end
          end else begin
            state   <= RUN;
            run_len <= 2'd0;
          end
        end
        default: begin
          state   <= RUN;
          run_len <= 2'd0;
        end
      endcase
    end
  end

`ifdef STALL_STATS_EN
  // Bubble statistics: counts every bubble cycle and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 16'd0;
    end else if (idex_bubble && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// tb_pipe_dest_tracker: table-driven directed bench for pipe_dest_tracker.
// Each record holds one cycle of inputs, the expected combinational enables
// for those inputs, and the expected registered state after the clock edge.
// When STALL_STATS_EN is defined, the bench also exercises stall_count.
module tb_pipe_dest_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode_decode;
  logic [2:0]  w_decode;
  logic        stall;
  logic        hold;
  logic [2:0]  w_exec;
  logic [2:0]  w_mem;
  logic [2:0]  w_wb;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_bubble;
  logic        stall_err;
`ifdef STALL_STATS_EN
  logic [15:0] stall_count;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic [2:0] wd;
    logic       st;
    logic       hd;
    logic       e_pc;
    logic       e_bub;
    logic [2:0] e_exec;
    logic [2:0] e_mem;
    logic [2:0] e_wb;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   num_checks = 0;
  int   num_fails  = 0;

  pipe_dest_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .opcode_decode (opcode_decode),
    .w_decode      (w_decode),
    .stall         (stall),
    .hold          (hold),
    .w_exec        (w_exec),
    .w_mem         (w_mem),
    .w_wb          (w_wb),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_bubble   (idex_bubble),
    .stall_err     (stall_err)
`ifdef STALL_STATS_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  // 10-time-unit free-running clock
  always #5 clk = ~clk;

  // Appends one record to the vector table
  function automatic void add_vec(input logic r, input logic [3:0] op, input logic [2:0] wd,
                                  input logic st, input logic hd, input logic e_pc,
                                  input logic e_bub, input logic [2:0] e_exec,
                                  input logic [2:0] e_mem, input logic [2:0] e_wb,
                                  input logic e_err);
    vec_t v;
    v.rst = r; v.op = op; v.wd = wd; v.st = st; v.hd = hd;
    v.e_pc = e_pc; v.e_bub = e_bub;
    v.e_exec = e_exec; v.e_mem = e_mem; v.e_wb = e_wb; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  // Single comparison with failure reporting
  task automatic check_output(input string name, input int idx,
                              input logic [15:0] actual, input logic [15:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, idx, actual, expected);
    end
  endtask

  // Drive one cycle: check the enables for the driven inputs, clock, then check state
  task automatic apply_stimulus(input vec_t v, input int idx);
    rst           = v.rst;
    opcode_decode = v.op;
    w_decode      = v.wd;
    stall         = v.st;
    hold          = v.hd;
    #1;
    check_output("pc_en",       idx, {15'd0, pc_en},       {15'd0, v.e_pc});
    check_output("ifid_en",     idx, {15'd0, ifid_en},     {15'd0, v.e_pc});
    check_output("idex_bubble", idx, {15'd0, idex_bubble}, {15'd0, v.e_bub});
    @(posedge clk);
    #1;
    check_output("w_exec",    idx, {13'd0, w_exec},    {13'd0, v.e_exec});
    check_output("w_mem",     idx, {13'd0, w_mem},     {13'd0, v.e_mem});
    check_output("w_wb",      idx, {13'd0, w_wb},      {13'd0, v.e_wb});
    check_output("stall_err", idx, {15'd0, stall_err}, {15'd0, v.e_err});
  endtask

  // Main test sequence
  initial begin
    vec_t v;
    rst = 1'b1; opcode_decode = 4'd0; w_decode = 3'd0; stall = 1'b0; hold = 1'b0;

    //      rst op  wd  st hd  pc bub exec mem wb err
    add_vec(1, 0,  0,  0, 0,  1, 0,  0,   0,  0, 0);  // 0 reset
    add_vec(0, 1,  3,  0, 0,  1, 0,  3,   0,  0, 0);  // 1 issue tag 3
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   3,  0, 0);  // 2
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  3, 0);  // 3
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  0, 0);  // 4 drained
    add_vec(0, 11, 5,  0, 0,  1, 0,  0,   0,  0, 0);  // 5 store: no write
    add_vec(0, 12, 6,  0, 0,  1, 0,  0,   0,  0, 0);  // 6 no write
    add_vec(0, 10, 7,  0, 0,  1, 0,  7,   0,  0, 0);  // 7 highest writing opcode
    add_vec(0, 5,  0,  0, 0,  1, 0,  0,   7,  0, 0);  // 8 writing, dest 0
    add_vec(0, 15, 1,  0, 0,  1, 0,  0,   0,  7, 0);  // 9 opcode 15 no write
    add_vec(0, 2,  4,  0, 0,  1, 0,  4,   0,  0, 0);  // 10 issue tag 4
    add_vec(0, 2,  4,  1, 0,  0, 1,  0,   4,  0, 0);  // 11 stall 1
    add_vec(0, 2,  4,  1, 0,  0, 1,  0,   0,  4, 0);  // 12 stall 2
    add_vec(0, 2,  4,  1, 0,  0, 1,  0,   0,  0, 0);  // 13 stall 3, no error
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  0, 0);  // 14 back to RUN
    add_vec(0, 1,  3,  0, 0,  1, 0,  3,   0,  0, 0);  // 15
    add_vec(0, 1,  2,  0, 0,  1, 0,  2,   3,  0, 0);  // 16
    add_vec(0, 1,  1,  0, 0,  1, 0,  1,   2,  3, 0);  // 17 tags 1,2,3
    add_vec(0, 1,  5,  1, 1,  0, 0,  1,   2,  3, 0);  // 18 hold beats stall
    add_vec(0, 1,  5,  1, 1,  0, 0,  1,   2,  3, 0);  // 19
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   1,  2, 0);  // 20
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  1, 0);  // 21 stall 1
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 0);  // 22 stall 2
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 0);  // 23 stall 3
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 1);  // 24 stall 4 -> error
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  0, 1);  // 25 sticky
    add_vec(0, 0,  0,  1, 1,  0, 0,  0,   0,  0, 1);  // 26
    add_vec(0, 3,  6,  0, 0,  1, 0,  6,   0,  0, 1);  // 27
    add_vec(1, 1,  2,  1, 1,  0, 0,  0,   0,  0, 0);  // 28 reset beats hold/stall
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  0, 0);  // 29
    add_vec(0, 4,  5,  0, 0,  1, 0,  5,   0,  0, 0);  // 30
    add_vec(0, 4,  5,  1, 0,  0, 1,  0,   5,  0, 0);  // 31 enter STALLED
    add_vec(1, 4,  5,  1, 0,  0, 1,  0,   0,  0, 0);  // 32 reset mid-stall
    add_vec(0, 0,  0,  0, 0,  1, 0,  0,   0,  0, 0);  // 33
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 0);  // 34 stall 1
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 0);  // 35 stall 2
    add_vec(0, 0,  0,  1, 1,  0, 0,  0,   0,  0, 0);  // 36 held, no count
    add_vec(0, 0,  0,  1, 1,  0, 0,  0,   0,  0, 0);  // 37 held, no count
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 0);  // 38 stall 3
    add_vec(0, 0,  0,  1, 0,  0, 1,  0,   0,  0, 1);  // 39 stall 4 -> error

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Long stall right after an issue: tag drains, EX gets bubbles, error on 4th
    v = '{rst: 1'b1, op: 4'd0, wd: 3'd0, st: 1'b0, hd: 1'b0, e_pc: 1'b1, e_bub: 1'b0,
          e_exec: 3'd0, e_mem: 3'd0, e_wb: 3'd0, e_err: 1'b0};
    apply_stimulus(v, 100);
    v.rst = 1'b0; v.op = 4'd1; v.wd = 3'd2; v.e_exec = 3'd2;
    apply_stimulus(v, 101);
    for (int i = 0; i < 6; i++) begin
      v.st     = 1'b1;
      v.e_pc   = 1'b0;
      v.e_bub  = 1'b1;
      v.e_exec = 3'd0;
      v.e_mem  = (i == 0) ? 3'd2 : 3'd0;
      v.e_wb   = (i == 1) ? 3'd2 : 3'd0;
      v.e_err  = (i >= 3);
      apply_stimulus(v, 102 + i);
    end

`ifdef STALL_STATS_EN
    // Bubble counter: five bubbles, held cycles ignored, cleared by reset
    v = '{rst: 1'b1, op: 4'd0, wd: 3'd0, st: 1'b0, hd: 1'b0, e_pc: 1'b1, e_bub: 1'b0,
          e_exec: 3'd0, e_mem: 3'd0, e_wb: 3'd0, e_err: 1'b0};
    apply_stimulus(v, 200);
    check_output("stall_count", 200, stall_count, 16'd0);
    v.rst = 1'b0; v.op = 4'd3; v.wd = 3'd1; v.e_exec = 3'd1;
    apply_stimulus(v, 201);
    v.st = 1'b1; v.e_pc = 1'b0; v.e_bub = 1'b1; v.e_exec = 3'd0;
    for (int i = 0; i < 5; i++) begin
      v.e_mem = (i == 0) ? 3'd1 : 3'd0;
      v.e_wb  = (i == 1) ? 3'd1 : 3'd0;
      v.e_err = (i >= 3);
      apply_stimulus(v, 202 + i);
    end
    check_output("stall_count", 207, stall_count, 16'd5);
    v.hd = 1'b1; v.e_bub = 1'b0;
    apply_stimulus(v, 208);
    check_output("stall_count", 208, stall_count, 16'd5);
    v.hd = 1'b0; v.rst = 1'b1; v.e_bub = 1'b1; v.e_err = 1'b0;
    apply_stimulus(v, 209);
    check_output("stall_count", 209, stall_count, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule
